iic_cmd_arbiter: RTL

Shares the single camera IIC master (Driver_IIC) between two command sources, typically the OV5647 power-up sequencer and a runtime register tuner (exposure/gain/test-pattern writes), in the 100 MHz system clock domain. Each requester presents one complete IIC transaction: write or read, 8- or 16-bit register address, and data. The block arbitrates round-robin, launches the transaction on the driver's edge-triggered strobe and tracks the driver's active-low busy flag to completion. It then returns read data and a done pulse to the owning requester.

---
 rtl/iic_cmd_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/iic_cmd_arbiter.sv
// rtl/iic_cmd_arbiter.sv - round-robin arbiter sharing one IIC driver between two command sources
// Optional wait-state timeout abort: define IIC_ARB_TIMEOUT_EN.
module iic_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0,
    input  logic       i_rd0,
    input  logic       i_mode0,
    input  logic [7:0] i_slave0,
    input  logic [7:0] i_addr_h0,
    input  logic [7:0] i_addr_l0,
    input  logic [7:0] i_wdata0,
    input  logic       i_req1,
    input  logic       i_rd1,
    input  logic       i_mode1,
    input  logic [7:0] i_slave1,
    input  logic [7:0] i_addr_h1,
    input  logic [7:0] i_addr_l1,
    input  logic [7:0] i_wdata1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_done0,
    output logic       o_done1,
    output logic [7:0] o_rdata,
    output logic       o_err,
    output logic       o_iic_write,
    output logic       o_iic_read,
    output logic       o_iic_mode,
    output logic [7:0] o_slave_addr,
    output logic [7:0] o_reg_addr_h,
    output logic [7:0] o_reg_addr_l,
    output logic [7:0] o_data_w,
    input  logic       i_iic_busy,
    input  logic [7:0] i_iic_rdata
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_GRANT      = 3'd1;
    localparam logic [2:0] S_LAUNCH     = 3'd2;
    localparam logic [2:0] S_WAIT_START = 3'd3;
    localparam logic [2:0] S_WAIT_END   = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0] state;
    logic       last_served;
    logic       owner;
    logic       after_done;
    logic       cmd_rd;
    logic       req0_eff;
    logic       req1_eff;
    logic       strobe_out;
    logic       busy_seen_low;
    logic       finish_ok;
    logic       finish_tmo;
    logic       timeout_hit;

    // The requester just served is ignored for the single IDLE cycle after DONE.
    assign req0_eff = i_req0 & ~(after_done & ~last_served);
    assign req1_eff = i_req1 & ~(after_done &  last_served);

    assign strobe_out    = o_iic_write | o_iic_read;
    assign busy_seen_low = (state == S_WAIT_START) && !i_iic_busy;
    assign finish_ok     = (state == S_WAIT_END) && i_iic_busy;
    assign finish_tmo    = timeout_hit && !finish_ok && !busy_seen_low;

`ifdef IIC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait = (state == S_WAIT_START) || (state == S_WAIT_END);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wait_cnt <= '0;
        end else if ((state == S_LAUNCH) || busy_seen_low) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = in_wait && (wait_cnt == TMO_LAST);
`else
    logic [CNT_W-1:0] unused_tmo;

    assign unused_tmo  = TMO_LAST;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            last_served  <= 1'b1;
            owner        <= 1'b0;
            after_done   <= 1'b0;
            cmd_rd       <= 1'b0;
            o_gnt0       <= 1'b0;
            o_gnt1       <= 1'b0;
            o_done0      <= 1'b0;
            o_done1      <= 1'b0;
            o_rdata      <= 8'h00;
            o_err        <= 1'b0;
            o_iic_write  <= 1'b0;
            o_iic_read   <= 1'b0;
            o_iic_mode   <= 1'b0;
            o_slave_addr <= 8'h00;
            o_reg_addr_h <= 8'h00;
            o_reg_addr_l <= 8'h00;
            o_data_w     <= 8'h00;
        end else begin
            o_done0    <= 1'b0;
            o_done1    <= 1'b0;
            after_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req0_eff || req1_eff) begin
                        owner <= (req0_eff && req1_eff) ? ~last_served : req1_eff;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    o_gnt0 <= ~owner;
                    o_gnt1 <=  owner;
                    if (owner) begin
                        cmd_rd       <= i_rd1;
                        o_iic_mode   <= i_mode1;
                        o_slave_addr <= i_slave1;
                        o_reg_addr_h <= i_addr_h1;
                        o_reg_addr_l <= i_addr_l1;
                        o_data_w     <= i_wdata1;
                    end else begin
                        cmd_rd       <= i_rd0;
                        o_iic_mode   <= i_mode0;
                        o_slave_addr <= i_slave0;
                        o_reg_addr_h <= i_addr_h0;
                        o_reg_addr_l <= i_addr_l0;
                        o_data_w     <= i_wdata0;
                    end
                    state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    // Command fields sit stable for one cycle before the strobe rises.
                    if (strobe_out) begin
                        o_iic_write <= 1'b0;
                        o_iic_read  <= 1'b0;
                        state       <= S_WAIT_START;
                    end else begin
                        o_iic_write <= ~cmd_rd;
                        o_iic_read  <=  cmd_rd;
                    end
                end
                S_WAIT_START: begin
                    if (!i_iic_busy) begin
                        state <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                end
                S_DONE: begin
                    o_gnt0      <= 1'b0;
                    o_gnt1      <= 1'b0;
                    last_served <= owner;
                    after_done  <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (finish_ok || finish_tmo) begin
                state   <= S_DONE;
                o_done0 <= ~owner;
                o_done1 <=  owner;
                o_err   <= finish_tmo;
                if (finish_tmo) begin
                    o_rdata <= 8'h00;
                end else if (cmd_rd) begin
                    o_rdata <= i_iic_rdata;
                end
            end
        end
    end

endmodule
